gateway_tx_arbiter: RTL and testbench
=====================================

// Module: gateway_tx_arbiter
// PURPOSE
// - Shares one vFPGA's single egress port into the vIO switch among its five outgoing paths (HOST, RDMA, TCP, BYPASS, P2P).
// - Packet-granular round-robin arbitration; attaches tdest route_id {4'b0, sender=ID, receiver, 2'b0} and tid=ID per packet.
// - Sits between the vFPGA user streams and the vIO switch ingress, after gateway_send route generation.
// PARAMETERS
// - ID         0  this vFPGA's index (sender_id, tid)
// - N_REGIONS  2  number of vFPGA regions; infrastructure ports start at N_REGIONS
// - N_PATHS    5  fixed path count (0=HOST,1=RDMA,2=TCP,3=BYPASS,4=P2P); other values unsupported
// PORTS
// - aclk          in   1             clock
// - aresetn       in   1             synchronous, active-low reset
// - route_ctrl    in   14            host-programmed route; [5:2] = P2P receiver_id
// - s_axis[N_PATHS] in AXI4S         per-path user streams (AXI_DATA_BITS from lynxTypes)
// - m_axis        out  AXI4SR        to vIO switch; tdest[13:0], tid[PID_BITS-1:0]
// - p2p_drop      out  1             one-cycle pulse when an illegal P2P packet finishes draining
// - pkt_cnt       out  N_PATHS*32    per-path forwarded-packet counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset: FSM=IDLE, rr_ptr=4 (path 0 wins first), m_axis.tvalid=0, all s_axis.tready=0, p2p_drop=0, pkt_cnt=0.
// - FSM IDLE: any s_axis.tvalid -> pick first valid path searching rr_ptr+1, +2, ... mod N_PATHS; latch grant, tdest, rr_ptr=grant.
//   - Grant P2P with route_ctrl[5:2] >= N_REGIONS or == ID -> DRAIN; else -> FWD. No valid -> stay IDLE.
// - FWD: only s_axis[grant].tready may be 1; beats move into output skid buffer; tdest/tid constant for whole packet.
//   - Handshake with tlast=1 -> IDLE, pkt_cnt[grant]++ (wrap at 2^32). One idle arbitration cycle between packets.
// - DRAIN: s_axis[4].tready=1 unconditionally, nothing forwarded; tlast handshake -> p2p_drop=1 for one cycle, -> IDLE.
// - Receiver map: HOST=N_REGIONS+1, RDMA=N_REGIONS+2, TCP=N_REGIONS+3, BYPASS=N_REGIONS+4, P2P=route_ctrl[5:2] sampled at grant.
// - route_ctrl changes mid-packet: no effect until next P2P grant.
// - Latency: first beat on m_axis 2 cycles after tvalid seen in IDLE (1 arbitrate + 1 register); steady state 1 beat/cycle.
// - Output skid: 2 entries; s ready = skid not full; m_axis.tvalid held with data stable until tready (AXI rule).
// - Backpressure: m_axis.tready=0 fills skid, then deasserts granted tready; no beat lost or duplicated.
// - Non-granted paths never see tready=1; a path holding tvalid is served within N_PATHS-1 packets (no starvation).
// - Reset mid-packet: state and skid flushed, partial packet discarded; upstream must also reset.
// CONFIGURATION
// - GW_TX_PKT_CNT_EN defined: pkt_cnt implemented as above, 32-bit wrap per path.
// - Not defined: pkt_cnt tied to 0, counter logic absent; arbitration/drop behaviour unchanged.
// STRUCTURE
// - Package gw_tx_pkg: path enum (GW_PATH_HOST..GW_PATH_P2P), PORT_* offsets, fsm_t {IDLE,FWD,DRAIN},
//   build_route_id(sender, receiver) function.
// - One sub-module: gw_tx_skid (2-entry AXI4SR register slice carrying tdata/tkeep/tlast/tdest/tid).
// TESTING
// - ID=0,N_REGIONS=2; single 3-beat HOST packet, m tready=1 -> m_axis beats at cycles 2,3,4, tdest=14'h000C, tid=0, pkt_cnt[0]=1.
// - All 5 paths valid, 1-beat packets, route_ctrl=14'h0004 -> grant order 0,1,2,3,4; P2P tdest=14'h0004.
// - P2P with route_ctrl[5:2]=0 (self) 4-beat packet -> no m_axis beats, tready=1 for 4 cycles, p2p_drop single pulse.
// - RDMA 8-beat packet, m tready toggled 1010... -> all 8 beats in order, tdest=14'h0010 stable, tlast only on beat 8.
// - Assert aresetn=0 at beat 2 of a TCP packet -> m tvalid=0 next cycle, pkt_cnt all 0, next grant path 0.
// - Build without GW_TX_PKT_CNT_EN, 10 HOST packets -> pkt_cnt=0, traffic identical to counted build.

Source files
------------

// File: rtl/gw_tx_pkg.sv
// Shared types for the gateway TX arbiter: path indices, receiver port offsets,
// FSM states and the route_id layout placed on tdest.
package gw_tx_pkg;

   typedef enum logic [2:0] {
      GW_PATH_HOST   = 3'd0,
      GW_PATH_RDMA   = 3'd1,
      GW_PATH_TCP    = 3'd2,
      GW_PATH_BYPASS = 3'd3,
      GW_PATH_P2P    = 3'd4
   } gw_path_t;

   // Infrastructure receiver ports sit at N_REGIONS + offset
   localparam int unsigned PORT_HOST   = 1;
   localparam int unsigned PORT_RDMA   = 2;
   localparam int unsigned PORT_TCP    = 3;
   localparam int unsigned PORT_BYPASS = 4;

   localparam int unsigned ROUTE_BITS = 14;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      DRAIN
   } fsm_t;

   function automatic logic [ROUTE_BITS-1:0] build_route_id(input logic [3:0] sender,
                                                            input logic [3:0] receiver);
      return {4'b0000, sender, receiver, 2'b00};
   endfunction

endpackage

// File: rtl/gw_tx_skid.sv
// Two-entry AXI4SR register slice; input ready is "not full", output held stable
// until accepted.
module gw_tx_skid #(
   parameter int unsigned DATA_BITS = 64,
   parameter int unsigned DEST_BITS = 14,
   parameter int unsigned ID_BITS   = 6
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [DATA_BITS-1:0]   s_tdata,
   input  logic [DATA_BITS/8-1:0] s_tkeep,
   input  logic                   s_tlast,
   input  logic [DEST_BITS-1:0]   s_tdest,
   input  logic [ID_BITS-1:0]     s_tid,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_BITS-1:0]   m_tdata,
   output logic [DATA_BITS/8-1:0] m_tkeep,
   output logic                   m_tlast,
   output logic [DEST_BITS-1:0]   m_tdest,
   output logic [ID_BITS-1:0]     m_tid
);

   localparam int unsigned W = DATA_BITS + DATA_BITS/8 + 1 + DEST_BITS + ID_BITS;

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic [1:0]   count_q, count_d;
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic         push, pop;

   always_comb begin
      s_tready = (count_q != 2'd2);
      m_tvalid = (count_q != 2'd0);
      push     = s_tvalid & s_tready;
      pop      = m_tvalid & m_tready;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_q] = {s_tdata, s_tkeep, s_tlast, s_tdest, s_tid};
      end
      wr_d    = wr_q ^ push;
      rd_d    = rd_q ^ pop;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      {m_tdata, m_tkeep, m_tlast, m_tdest, m_tid} = mem_q[rd_q];
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         count_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/gateway_tx_arbiter.sv
// Packet-granular round-robin of the five vFPGA egress paths onto one vIO switch port.
// Define GW_TX_PKT_CNT_EN to implement the per-path forwarded-packet counters on pkt_cnt.
module gateway_tx_arbiter
   import gw_tx_pkg::*;
#(
   parameter int unsigned ID            = 0,
   parameter int unsigned N_REGIONS     = 2,
   parameter int unsigned N_PATHS       = 5,
   parameter int unsigned AXI_DATA_BITS = 64,
   parameter int unsigned PID_BITS      = 6
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic [13:0]                          route_ctrl,
   input  logic [N_PATHS-1:0]                   s_axis_tvalid,
   output logic [N_PATHS-1:0]                   s_axis_tready,
   input  logic [N_PATHS*AXI_DATA_BITS-1:0]     s_axis_tdata,
   input  logic [N_PATHS*AXI_DATA_BITS/8-1:0]   s_axis_tkeep,
   input  logic [N_PATHS-1:0]                   s_axis_tlast,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [AXI_DATA_BITS-1:0]             m_axis_tdata,
   output logic [AXI_DATA_BITS/8-1:0]           m_axis_tkeep,
   output logic                                 m_axis_tlast,
   output logic [13:0]                          m_axis_tdest,
   output logic [PID_BITS-1:0]                  m_axis_tid,
   output logic                                 p2p_drop,
   output logic [N_PATHS*32-1:0]                pkt_cnt
);

   localparam int unsigned KB  = AXI_DATA_BITS / 8;
   localparam int unsigned P2P = 32'(GW_PATH_P2P);

   fsm_t                     state_q, state_d;
   logic [2:0]               grant_q, grant_d;
   logic [2:0]               rr_q, rr_d;
   logic [13:0]              tdest_q, tdest_d;
   logic                     drop_q, drop_d;
   logic [2:0]               idx, pick;
   logic                     pick_vld, p2p_bad;
   logic [3:0]               receiver;
   logic                     sel_tvalid, sel_tlast, in_hs, skid_ready;
   logic [AXI_DATA_BITS-1:0] sel_tdata;
   logic [KB-1:0]            sel_tkeep;
   logic                     route_unused;

   assign route_unused = ^{route_ctrl[13:6], route_ctrl[1:0]};

   // First valid path after the last grant, wrapping modulo N_PATHS
   always_comb begin
      idx      = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int unsigned i = 1; i <= N_PATHS; i++) begin
         idx = 3'((32'(rr_q) + i) % N_PATHS);
         if (!pick_vld && s_axis_tvalid[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
      unique case (pick)
         GW_PATH_HOST:   receiver = 4'(N_REGIONS + PORT_HOST);
         GW_PATH_RDMA:   receiver = 4'(N_REGIONS + PORT_RDMA);
         GW_PATH_TCP:    receiver = 4'(N_REGIONS + PORT_TCP);
         GW_PATH_BYPASS: receiver = 4'(N_REGIONS + PORT_BYPASS);
         default:        receiver = route_ctrl[5:2];
      endcase
      p2p_bad = (32'(route_ctrl[5:2]) >= N_REGIONS) || (route_ctrl[5:2] == 4'(ID));
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= 3'(N_PATHS - 1);
         tdest_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         tdest_q <= tdest_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      tdest_d = tdest_q;
      drop_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               rr_d    = pick;
               tdest_d = build_route_id(4'(ID), receiver);
               state_d = (32'(pick) == P2P && p2p_bad) ? DRAIN : FWD;
            end
         end
         FWD: begin
            if (in_hs && sel_tlast) state_d = IDLE;
         end
         DRAIN: begin
            if (s_axis_tvalid[P2P] && s_axis_tlast[P2P]) begin
               state_d = IDLE;
               drop_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_tvalid    = s_axis_tvalid[grant_q];
      sel_tlast     = s_axis_tlast[grant_q];
      sel_tdata     = s_axis_tdata[32'(grant_q)*AXI_DATA_BITS +: AXI_DATA_BITS];
      sel_tkeep     = s_axis_tkeep[32'(grant_q)*KB +: KB];
      s_axis_tready = '0;
      if (state_q == FWD) s_axis_tready[grant_q] = skid_ready;
      if (state_q == DRAIN) s_axis_tready[P2P] = 1'b1;
      in_hs    = (state_q == FWD) && sel_tvalid && skid_ready;
      p2p_drop = drop_q;
   end

   gw_tx_skid #(
      .DATA_BITS (AXI_DATA_BITS),
      .DEST_BITS (14),
      .ID_BITS   (PID_BITS)
   ) u_skid (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_tvalid (in_hs),
      .s_tready (skid_ready),
      .s_tdata  (sel_tdata),
      .s_tkeep  (sel_tkeep),
      .s_tlast  (sel_tlast),
      .s_tdest  (tdest_q),
      .s_tid    (PID_BITS'(ID)),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready),
      .m_tdata  (m_axis_tdata),
      .m_tkeep  (m_axis_tkeep),
      .m_tlast  (m_axis_tlast),
      .m_tdest  (m_axis_tdest),
      .m_tid    (m_axis_tid)
   );

`ifdef GW_TX_PKT_CNT_EN
   logic [31:0] cnt_q [N_PATHS];
   logic [31:0] cnt_d [N_PATHS];

   always_comb begin
      cnt_d   = cnt_q;
      pkt_cnt = '0;
      if (in_hs && sel_tlast) cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
      for (int unsigned i = 0; i < N_PATHS; i++) pkt_cnt[i*32 +: 32] = cnt_q[i];
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < N_PATHS; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_gateway_tx_arbiter.sv
// Randomized bench for gateway_tx_arbiter: packet-level round-robin reference model and
// per-beat scoreboard, plus directed latency / drain / backpressure / reset scenarios.
module tb_gateway_tx_arbiter;

   localparam int unsigned NP     = 5;
   localparam int unsigned DW     = 64;
   localparam int unsigned KW     = DW / 8;
   localparam int unsigned PW     = 6;
   localparam int unsigned ID     = 0;
   localparam int unsigned N_REG  = 2;
   localparam int unsigned BUDGET = 2000;
`ifdef GW_TX_PKT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;
   typedef logic [DW+KW+1+14+PW-1:0] pay_t;

   logic                aclk = 1'b0;
   logic                aresetn;
   logic [13:0]         route_ctrl;
   logic [NP-1:0]       s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [NP*DW-1:0]    s_axis_tdata;
   logic [NP*KW-1:0]    s_axis_tkeep;
   logic                m_axis_tvalid, m_axis_tready, m_axis_tlast, p2p_drop;
   logic [DW-1:0]       m_axis_tdata;
   logic [KW-1:0]       m_axis_tkeep;
   logic [13:0]         m_axis_tdest;
   logic [PW-1:0]       m_axis_tid;
   logic [NP*32-1:0]    pkt_cnt;

   gateway_tx_arbiter #(
      .ID            (ID),
      .N_REGIONS     (N_REG),
      .N_PATHS       (NP),
      .AXI_DATA_BITS (DW),
      .PID_BITS      (PW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .route_ctrl    (route_ctrl),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdest  (m_axis_tdest),
      .m_axis_tid    (m_axis_tid),
      .p2p_drop      (p2p_drop),
      .pkt_cnt       (pkt_cnt)
   );

   always #5 aclk = ~aclk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // Packet plan, source stream contents and expected output
   int unsigned pk_len [NP][16];
   int unsigned pk_n   [NP];
   beat_t       src_mem [NP][64];
   int unsigned src_len [NP];
   int unsigned sp      [NP];
   int unsigned fwd_exp [NP];
   int unsigned rc_recv, drops_exp, drops_seen, p2p_rdy_cyc, cyc;
   int          first_cyc, last_cyc;
   logic [13:0] first_dest, last_dest;
   pay_t        exp_q [$];
   pay_t        stall_pay;
   bit          stall_prev;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [13:0] exp_dest(input int unsigned p);
      int unsigned recv = (p == NP - 1) ? rc_recv : N_REG + 1 + p;
      return {4'b0000, 4'(ID), 4'(recv), 2'b00};
   endfunction

   task automatic clear_pkts();
      for (int unsigned p = 0; p < NP; p++) pk_n[p] = 0;
   endtask

   task automatic add_pkt(input int unsigned p, input int unsigned len);
      pk_len[p][pk_n[p]] = len;
      pk_n[p]++;
   endtask

   task automatic set_route(input int unsigned recv, input bit rnd);
      rc_recv    = recv;
      route_ctrl = rnd ? {8'($urandom()), 4'(recv), 2'($urandom())} : {8'h00, 4'(recv), 2'b00};
   endtask

   // Generate source data and predict output order: plain round-robin over paths with work left
   task automatic build_round();
      int unsigned k [NP];
      int unsigned bp [NP];
      int unsigned rr, left, p;
      bit          bad;
      exp_q.delete();
      drops_exp = 0;
      left      = 0;
      for (int unsigned q = 0; q < NP; q++) begin
         src_len[q] = 0;
         sp[q]      = 0;
         fwd_exp[q] = 0;
         k[q]       = 0;
         bp[q]      = 0;
         left      += pk_n[q];
         for (int unsigned j = 0; j < pk_n[q]; j++)
            for (int unsigned b = 0; b < pk_len[q][j]; b++) begin
               src_mem[q][src_len[q]] = '{data: {$urandom(), $urandom()}, keep: KW'($urandom()),
                                          last: (b == pk_len[q][j] - 1)};
               src_len[q]++;
            end
      end
      bad = (rc_recv >= N_REG) || (rc_recv == ID);
      rr  = NP - 1;
      while (left > 0) begin
         p = 0;
         for (int unsigned i = 1; i <= NP; i++) begin
            p = (rr + i) % NP;
            if (k[p] < pk_n[p]) break;
         end
         rr = p;
         if (p == NP - 1 && bad) drops_exp++;
         else begin
            for (int unsigned b = 0; b < pk_len[p][k[p]]; b++)
               exp_q.push_back({src_mem[p][bp[p] + b], exp_dest(p), PW'(ID)});
            fwd_exp[p]++;
         end
         bp[p] += pk_len[p][k[p]];
         k[p]++;
         left--;
      end
   endtask

   task automatic drive(input logic [NP-1:0] hs, input int unsigned mode, input bit gaps);
      bit v, first;
      for (int unsigned p = 0; p < NP; p++) begin
         if (hs[p]) sp[p]++;
         if (sp[p] >= src_len[p]) v = 1'b0;
         else if (s_axis_tvalid[p] && !hs[p]) v = 1'b1;
         else begin
            first = (sp[p] == 0) || src_mem[p][sp[p] - 1].last;
            v     = first || !gaps || ($urandom_range(3) != 0);
         end
         s_axis_tvalid[p] = v;
         if (sp[p] < src_len[p]) begin
            s_axis_tdata[p*DW +: DW] = src_mem[p][sp[p]].data;
            s_axis_tkeep[p*KW +: KW] = src_mem[p][sp[p]].keep;
            s_axis_tlast[p]          = src_mem[p][sp[p]].last;
         end else begin
            s_axis_tdata[p*DW +: DW] = '0;
            s_axis_tkeep[p*KW +: KW] = '0;
            s_axis_tlast[p]          = 1'b0;
         end
      end
      case (mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = (cyc % 2 == 0);
         default: m_axis_tready = ($urandom_range(9) < 7);
      endcase
   endtask

   // Sample at negedge, then advance sources just after the next rising edge
   task automatic step(input int unsigned mode, input bit gaps);
      logic [NP-1:0] hs;
      pay_t          pay;
      @(negedge aclk);
      hs  = s_axis_tvalid & s_axis_tready;
      pay = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest, m_axis_tid};
      check_eq("tready_onehot", $countones(s_axis_tready) > 1, 0);
      if (stall_prev) begin
         check_eq("hold_valid", m_axis_tvalid, 1);
         check_eq("hold_data", pay, stall_pay);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_pay  = pay;
      if (m_axis_tvalid && m_axis_tready) begin
         if (first_cyc < 0) begin
            first_cyc  = int'(cyc);
            first_dest = m_axis_tdest;
         end
         last_cyc  = int'(cyc);
         last_dest = m_axis_tdest;
         check_eq("extra_beat", m_axis_tvalid, exp_q.size() != 0);
         if (exp_q.size() != 0) check_eq("beat", pay, exp_q.pop_front());
      end
      if (p2p_drop) drops_seen++;
      if (s_axis_tready[NP-1]) p2p_rdy_cyc++;
      @(posedge aclk);
      #1;
      cyc++;
      drive(hs, mode, gaps);
   endtask

   task automatic do_reset();
      aresetn       = 1'b0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      m_axis_tready = 1'b0;
      repeat (3) begin
         @(posedge aclk);
         #1;
      end
      aresetn = 1'b1;
   endtask

   function automatic bit all_done();
      for (int unsigned p = 0; p < NP; p++) if (sp[p] < src_len[p]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_round(input bit rst, input int unsigned mode, input bit gaps);
      if (rst) do_reset();
      cyc         = 0;
      drops_seen  = 0;
      p2p_rdy_cyc = 0;
      first_cyc   = -1;
      last_cyc    = -1;
      stall_prev  = 1'b0;
      drive('0, mode, gaps);
      while (!(all_done() && exp_q.size() == 0 && drops_seen == drops_exp) && cyc < BUDGET)
         step(mode, gaps);
      check_eq("timeout", cyc >= BUDGET, 0);
      repeat (4) step(mode, gaps);
      check_eq("beats_left", exp_q.size(), 0);
      check_eq("drops", drops_seen, drops_exp);
      for (int unsigned p = 0; p < NP; p++)
         check_eq("pkt_cnt", pkt_cnt[p*32 +: 32], CNT_EN ? fwd_exp[p] : 0);
   endtask

   initial begin
      route_ctrl = '0;
      do_reset();
      @(negedge aclk);
      check_eq("rst_m_tvalid", m_axis_tvalid, 0);
      check_eq("rst_s_tready", s_axis_tready, 0);
      check_eq("rst_p2p_drop", p2p_drop, 0);
      check_eq("rst_pkt_cnt", |pkt_cnt, 0);
      @(posedge aclk);
      #1;

      // Single 3-beat HOST packet: beats at cycles 2..4
      clear_pkts();
      add_pkt(0, 3);
      set_route(1, 1'b0);
      build_round();
      run_round(1'b1, 0, 1'b0);
      check_eq("lat_first", first_cyc, 2);
      check_eq("lat_last", last_cyc, 4);
      check_eq("host_dest", last_dest, 14'h000C);

      // All paths valid, 1-beat packets, legal P2P receiver 1
      clear_pkts();
      for (int unsigned p = 0; p < NP; p++) add_pkt(p, 1);
      set_route(1, 1'b0);
      build_round();
      run_round(1'b1, 0, 1'b0);
      check_eq("p2p_dest", last_dest, 14'h0004);

      // P2P addressed to itself is drained
      clear_pkts();
      add_pkt(4, 4);
      set_route(0, 1'b0);
      build_round();
      run_round(1'b1, 0, 1'b0);
      check_eq("no_m_beats", first_cyc < 0, 1);
      check_eq("drain_rdy_cyc", p2p_rdy_cyc, 4);

      // RDMA 8 beats under alternating backpressure
      clear_pkts();
      add_pkt(1, 8);
      set_route(1, 1'b1);
      build_round();
      run_round(1'b1, 1, 1'b0);
      check_eq("rdma_dest", last_dest, 14'h0010);

      // Reset during beat 2 of a TCP packet
      clear_pkts();
      add_pkt(2, 4);
      set_route(1, 1'b0);
      build_round();
      do_reset();
      cyc        = 0;
      first_cyc  = -1;
      stall_prev = 1'b0;
      drive('0, 0, 1'b0);
      for (int i = 0; i < 20 && sp[2] < 2; i++) step(0, 1'b0);
      check_eq("rst_setup", sp[2], 2);
      aresetn       = 1'b0;
      s_axis_tvalid = '0;
      @(negedge aclk);
      check_eq("pre_rst_vld", m_axis_tvalid, 1);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      check_eq("mid_rst_m_tvalid", m_axis_tvalid, 0);
      check_eq("mid_rst_pkt_cnt", |pkt_cnt, 0);
      check_eq("mid_rst_s_tready", s_axis_tready, 0);
      @(posedge aclk);
      #1;
      clear_pkts();
      add_pkt(2, 1);
      add_pkt(0, 2);
      add_pkt(3, 1);
      build_round();
      run_round(1'b0, 0, 1'b0);
      check_eq("post_rst_grant", first_dest, 14'h000C);

      // Ten HOST packets with gaps and random backpressure
      clear_pkts();
      for (int unsigned j = 0; j < 10; j++) add_pkt(0, $urandom_range(1, 4));
      set_route(1, 1'b1);
      build_round();
      run_round(1'b1, 2, 1'b1);
      check_eq("host10_cnt", pkt_cnt[31:0], CNT_EN ? 32'd10 : 32'd0);

      // Random mixes across all paths and P2P receivers
      for (int r = 0; r < 10; r++) begin
         clear_pkts();
         for (int unsigned p = 0; p < NP; p++)
            for (int unsigned j = $urandom_range(0, 3); j > 0; j--) add_pkt(p, $urandom_range(1, 6));
         set_route($urandom_range(0, 3), 1'b1);
         build_round();
         run_round(1'b1, 2, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
